// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus scheduler: register address table,
// arbiter state encoding and a register-address lookup helper.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] RTC_CMD_REG = 8'h2F;

  // sec, min, hour, day, month, year, timer-sec, timer-min, timer-hour, spare
  localparam logic [7:0] RTC_REG_ADDR [0:15] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Returns {hit, index} of addr within the first num_regs table entries.
  function automatic logic [4:0] reg_lookup(input logic [7:0] addr, input logic [4:0] num_regs);
    logic [4:0] r;
    r = '0;
    for (int k = 15; k >= 0; k--) begin
      if ((5'(k) < num_regs) && (RTC_REG_ADDR[k] == addr)) r = {1'b1, 4'(k)};
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Periodic refresh tick counter and the refresh_pending request flag.
// Terminal counts that land while a sweep is pending or running are dropped.
module rtc_refresh_timer #(
  parameter int unsigned REFRESH_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic refresh_en,
  input  logic refresh_busy,
  input  logic sweep_start,
  output logic refresh_pending
);

  localparam int unsigned CW = $clog2(REFRESH_TICKS);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt        <= '0;
      refresh_pending <= 1'b0;
    end else if (!refresh_en) begin
      tick_cnt        <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (tick_cnt == CW'(REFRESH_TICKS - 1)) begin
        tick_cnt <= '0;
        if (!refresh_pending && !refresh_busy) refresh_pending <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end
      // A sweep only starts while pending, so this never races the set above.
      if (sweep_start) refresh_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbiter sharing the RTC bus engine between micro writes and refresh sweeps.
// Optional transaction timeout is built when RTC_TIMEOUT_EN is defined.
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS  = 1_000_000,
  parameter int unsigned NUM_REGS       = 9,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_en,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       bus_start,
  output logic       bus_write,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       shadow_we,
  output logic [3:0] shadow_idx,
  output logic [7:0] shadow_data,
  output logic       refresh_busy,
  output logic       sweep_done,
  output logic       bus_err,
  output state_t     dbg_state
);

  if (REFRESH_TICKS < 2) begin : g_bad_ticks
    $error("REFRESH_TICKS must be at least 2");
  end
  if ((NUM_REGS < 1) || (NUM_REGS > 16)) begin : g_bad_regs
    $error("NUM_REGS must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t     state;
  logic [3:0] idx;
  logic       last_write;
  logic       refresh_pending;
  logic       refresh_req;
  logic       grant_write;
  logic       sweep_start;
  logic [4:0] wr_hit;

  assign dbg_state   = state;
  assign refresh_req = refresh_en && (refresh_pending || refresh_busy);
  // Alternation: a write wins unless the previous grant was also a write.
  assign grant_write = wr_req && (!refresh_req || !last_write);
  assign sweep_start = (state == ST_IDLE) && !grant_write && refresh_req && refresh_pending;
  assign wr_hit      = reg_lookup(bus_addr, 5'(NUM_REGS));

  rtc_refresh_timer #(.REFRESH_TICKS(REFRESH_TICKS)) u_timer (
    .clk             (clk),
    .reset           (reset),
    .refresh_en      (refresh_en),
    .refresh_busy    (refresh_busy),
    .sweep_start     (sweep_start),
    .refresh_pending (refresh_pending)
  );

`ifdef RTC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      last_write   <= 1'b0;
      wr_ack       <= 1'b0;
      bus_start    <= 1'b0;
      bus_write    <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      shadow_we    <= 1'b0;
      shadow_idx   <= '0;
      shadow_data  <= '0;
      refresh_busy <= 1'b0;
      sweep_done   <= 1'b0;
`ifdef RTC_TIMEOUT_EN
      bus_err      <= 1'b0;
      to_cnt       <= '0;
`endif
    end else begin
      bus_start  <= 1'b0;
      wr_ack     <= 1'b0;
      shadow_we  <= 1'b0;
      sweep_done <= 1'b0;
`ifdef RTC_TIMEOUT_EN
      bus_err    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (grant_write) begin
            bus_write  <= 1'b1;
            bus_addr   <= wr_addr;
            bus_wdata  <= wr_data;
            last_write <= 1'b1;
            bus_start  <= 1'b1;
            state      <= ST_ISSUE;
          end else if (refresh_req) begin
            bus_write  <= 1'b0;
            bus_addr   <= RTC_REG_ADDR[sweep_start ? 4'd0 : idx];
            bus_wdata  <= '0;
            last_write <= 1'b0;
            bus_start  <= 1'b1;
            state      <= ST_ISSUE;
            if (sweep_start) begin
              refresh_busy <= 1'b1;
              idx          <= '0;
            end
          end else if (refresh_busy) begin
            // refresh_en dropped between sweep reads: abandon the rest.
            refresh_busy <= 1'b0;
            idx          <= '0;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef RTC_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus_done) begin
            state <= ST_COMMIT;
            if (bus_write) begin
              wr_ack <= 1'b1;
              if (wr_hit[4]) begin
                shadow_we   <= 1'b1;
                shadow_idx  <= wr_hit[3:0];
                shadow_data <= bus_wdata;
              end
            end else begin
              shadow_we   <= 1'b1;
              shadow_idx  <= idx;
              shadow_data <= bus_rdata;
              if (!refresh_en) begin
                refresh_busy <= 1'b0;
                idx          <= '0;
              end else if (idx == LAST_IDX) begin
                sweep_done   <= 1'b1;
                refresh_busy <= 1'b0;
                idx          <= '0;
              end else begin
                idx <= idx + 4'd1;
              end
            end
          end
`ifdef RTC_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            bus_err <= 1'b1;
            state   <= ST_IDLE;
            if (bus_write) begin
              wr_ack <= 1'b1;
            end else begin
              refresh_busy <= 1'b0;
              idx          <= '0;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler with a behavioural bus engine (done latency 4).
// Define RTC_TIMEOUT_EN to also exercise the transaction timeout.
module tb_rtc_bus_scheduler;
  import rtc_pkg::*;

  localparam logic [7:0] REG_ADDR [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                            8'h26, 8'h27, 8'h28, 8'h29};
  localparam int W_BUS = 0, W_SH = 1, W_ACK = 2, W_SWEEP = 3;

  logic       clk, reset, refresh_en, wr_req;
  logic [7:0] wr_addr, wr_data, bus_addr, bus_wdata, bus_rdata, shadow_data;
  logic       wr_ack, bus_start, bus_write, bus_done, shadow_we;
  logic       refresh_busy, sweep_done, bus_err;
  logic [3:0] shadow_idx;
  state_t     dbg_state;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rtc_bus_scheduler #(.REFRESH_TICKS(50), .NUM_REGS(9), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .refresh_en(refresh_en), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .bus_start(bus_start),
    .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_done(bus_done), .bus_rdata(bus_rdata), .shadow_we(shadow_we),
    .shadow_idx(shadow_idx), .shadow_data(shadow_data), .refresh_busy(refresh_busy),
    .sweep_done(sweep_done), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // Scoreboard state
  logic [16:0] exp_bus_q[$], bus_log[$];
  logic [11:0] exp_q[$], sh_log[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, req_cyc, start_cyc, done_cyc, ack_cyc, err_cyc;
  int ack_cnt, sweep_cnt, err_cnt, err_total = 0, eng_cnt;
  logic [7:0] eng_rdata;
  logic eng_mute = 1'b0;

  initial forever @(posedge clk) cyc++;

  // Bus engine model and output monitor, both evaluated mid-cycle.
  initial begin
    bus_done = 1'b0; bus_rdata = 8'hEE; eng_cnt = 0; eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_done = 1'b0; bus_rdata = 8'hEE;
      if (!reset) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt != 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            bus_done = 1'b1; bus_rdata = eng_rdata; done_cyc = cyc;
          end
        end
        if (bus_start) begin
          bus_log.push_back({bus_write, bus_addr, bus_write ? bus_wdata : 8'h00});
          start_cyc = cyc;
          eng_rdata = bus_addr + 8'h30;
          if (!eng_mute) eng_cnt = 4;
        end
      end
      if (shadow_we) sh_log.push_back({shadow_idx, shadow_data});
      if (wr_ack) begin ack_cnt++; ack_cyc = cyc; end
      if (sweep_done) sweep_cnt++;
      if (bus_err) begin err_cnt++; err_total++; err_cyc = cyc; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    exp_bus_q.delete(); bus_log.delete(); exp_q.delete(); sh_log.delete();
    ack_cnt = 0; sweep_cnt = 0; err_cnt = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0; refresh_en = 1'b0; wr_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  // Returns #1 after the negedge on which the condition became true.
  task automatic wait_for(input int what, input int n, input int budget, input string tag);
    int v;
    v = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      case (what)
        W_BUS:   v = bus_log.size();
        W_SH:    v = sh_log.size();
        W_ACK:   v = ack_cnt;
        default: v = sweep_cnt;
      endcase
      if (v >= n) break;
    end
    check({tag, " wait"}, 32'(v >= n), 32'd1);
  endtask

  task automatic exp_read(input int i);
    exp_bus_q.push_back({1'b0, REG_ADDR[i], 8'h00});
    exp_q.push_back({4'(i), REG_ADDR[i] + 8'h30});
  endtask

  task automatic compare_logs(input string tag);
    check({tag, " bus count"}, bus_log.size(), exp_bus_q.size());
    for (int i = 0; i < exp_bus_q.size(); i++)
      check($sformatf("%s bus[%0d]", tag, i), (i < bus_log.size()) ? bus_log[i] : 17'bx, exp_bus_q[i]);
    check({tag, " shadow count"}, sh_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s shadow[%0d]", tag, i), (i < sh_log.size()) ? sh_log[i] : 12'bx, exp_q[i]);
  endtask

  initial begin
    reset = 1'b0; refresh_en = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    clear_logs();
    repeat (2) @(negedge clk);
    #1;
    check("rst bus_start", bus_start, 0);
    check("rst wr_ack", wr_ack, 0);
    check("rst bus_addr", {bus_write, bus_addr, bus_wdata}, 0);
    check("rst shadow", {shadow_we, shadow_idx, shadow_data}, 0);
    check("rst busy/done/err", {refresh_busy, sweep_done, bus_err}, 0);
    check("rst state", dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;

    // Uncontended write to the minutes register
    @(negedge clk);
    wr_addr = 8'h22; wr_data = 8'h45; wr_req = 1'b1; req_cyc = cyc;
    wait_for(W_ACK, 1, 40, "wr ack");
    wr_req = 1'b0;
    check("wr start latency", start_cyc, req_cyc + 1);
    check("wr ack latency", ack_cyc, done_cyc + 1);
    exp_bus_q.push_back({1'b1, 8'h22, 8'h45});
    exp_q.push_back({4'd1, 8'h45});
    repeat (5) @(negedge clk);
    #1;
    compare_logs("wr");
    check("wr ack once", ack_cnt, 1);

    // Refresh-only sweep
    clear_logs();
    refresh_en = 1'b1;
    wait_for(W_SWEEP, 1, 300, "sweep");
    refresh_en = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    for (int i = 0; i < 9; i++) exp_read(i);
    compare_logs("sweep");
    check("sweep done once", sweep_cnt, 1);
    check("sweep busy after", refresh_busy, 0);

    // Write arriving mid-sweep is interleaved between reads 2 and 3
    reset_dut();
    refresh_en = 1'b1;
    wait_for(W_BUS, 3, 200, "mix read2");
    wr_addr = 8'h25; wr_data = 8'h77; wr_req = 1'b1;
    wait_for(W_ACK, 1, 60, "mix ack");
    wr_req = 1'b0;
    wait_for(W_SWEEP, 1, 200, "mix sweep");
    refresh_en = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) exp_read(i);
    exp_bus_q.push_back({1'b1, 8'h25, 8'h77});
    exp_q.push_back({4'd4, 8'h77});
    for (int i = 3; i < 9; i++) exp_read(i);
    compare_logs("mix");
    check("mix sweep once", sweep_cnt, 1);

    // refresh_en dropped while read 3 is in flight
    reset_dut();
    refresh_en = 1'b1;
    wait_for(W_BUS, 4, 200, "abort read3");
    refresh_en = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) exp_read(i);
    compare_logs("abort");
    check("abort no sweep_done", sweep_cnt, 0);
    check("abort busy", refresh_busy, 0);
    clear_logs();
    refresh_en = 1'b1;
    wait_for(W_SH, 1, 150, "restart");
    exp_read(0);
    compare_logs("restart");
    refresh_en = 1'b0;
    repeat (10) @(negedge clk);

    // Reset pulsed while a write is waiting on the engine
    reset_dut();
    @(negedge clk);
    wr_addr = 8'h23; wr_data = 8'h11; wr_req = 1'b1;
    wait_for(W_BUS, 1, 20, "rstw start");
    repeat (2) @(negedge clk);
    reset = 1'b0; wr_req = 1'b0;
    #1;
    check("rstw state", dbg_state, ST_IDLE);
    check("rstw bus", {bus_start, bus_write, bus_addr, bus_wdata}, 0);
    check("rstw pulses", {wr_ack, shadow_we, sweep_done, refresh_busy}, 0);
    check("rstw shadow", {shadow_idx, shadow_data}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("rstw no ack", ack_cnt, 0);
    check("rstw no shadow", sh_log.size(), 0);
    check("rstw idle", dbg_state, ST_IDLE);

`ifdef RTC_TIMEOUT_EN
    // Engine never answers: timeout after 20 WAIT cycles still acks the write
    reset_dut();
    eng_mute = 1'b1;
    @(negedge clk);
    wr_addr = 8'h24; wr_data = 8'h33; wr_req = 1'b1;
    wait_for(W_ACK, 1, 60, "to ack");
    wr_req = 1'b0;
    check("to err count", err_cnt, 1);
    check("to err cycle", err_cyc, start_cyc + 21);
    check("to ack with err", ack_cyc, err_cyc);
    @(negedge clk);
    #1;
    check("to idle", dbg_state, ST_IDLE);
    check("to no shadow", sh_log.size(), 0);
    eng_mute = 1'b0;
`else
    check("bus_err never", err_total, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
